mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline stage 4 (MEM) of the 5-stage RV32I core. It consumes the EX/MEM register, performs load/store accesses on a ready/valid data bus with stall, and aligns and sign-extends load data. It produces the MEM/WB pipeline register that feeds WB_stage: reg-write enable, read data, ALU result, rd and mem-to-reg select.

Parameters:
ADDR_W, 32, data-bus address width
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ex_mem_valid  in  1  EX/MEM holds a live instruction
ex_mem_alu_result  in  32  effective address, or ALU result for non-memory ops
ex_mem_store_data  in  32  rs2 value for stores
ex_mem_rd  in  5  destination register
ex_mem_reg_write  in  1  instruction writes rd
ex_mem_mem_read  in  1  load
ex_mem_mem_write  in  1  store
ex_mem_mem_to_reg  in  1  WB selects read data
ex_mem_funct3  in  3  access size and signedness
mem_stall  out  1  freeze PC/IF/ID/EX/EX-MEM this cycle
dbus_req  out  1  bus request
dbus_we  out  1  write strobe
dbus_addr  out  ADDR_W  word-aligned address
dbus_wdata  out  32  lane-replicated store data
dbus_be  out  4  byte enables
dbus_ready  in  1  bus accepts or completes the access this cycle
dbus_rdata  in  32  read word, valid when dbus_ready is high on a read
mem_wb_valid  out  1  MEM/WB holds a live instruction
mem_wb_reg_write  out  1  WB writes rd
mem_wb_read_data  out  32  aligned, extended load data
mem_wb_alu_result  out  32  forwarded ALU result
mem_wb_rd  out  5  destination register
mem_wb_mem_to_reg  out  1  WB mux select

Behaviour:
- Reset is asynchronous, active-high, on clk.
- Reset values:
  - state=IDLE; dbus_req=0, dbus_we=0, dbus_be=0, dbus_addr=0, dbus_wdata=0.
  - All mem_wb_* outputs are 0.
  - mem_stall is combinational and evaluates to 0 under reset.
- A memop is ex_mem_valid && (mem_read || mem_write).
- Non-memop instructions:
  - MEM/WB loads on the next edge: 1-cycle latency, no stall.
  - mem_wb_valid=ex_mem_valid; mem_wb_reg_write=ex_mem_reg_write && ex_mem_valid && rd!=0.
- FSM has two states, IDLE and ACCESS.
  - IDLE with a memop:
    - Latch address, size, sign, rd, control and store data.
    - Drive dbus_req=1, dbus_we=mem_write, dbus_addr, dbus_be and dbus_wdata (all registered).
    - Go to ACCESS.
    - Load a bubble into MEM/WB: mem_wb_valid=0, mem_wb_reg_write=0.
  - ACCESS with dbus_ready=0: hold all bus outputs stable and keep the MEM/WB bubble.
  - ACCESS with dbus_ready=1:
    - Drop dbus_req, dbus_we and dbus_be to 0; go to IDLE.
    - Load MEM/WB from the latched instruction; loads take aligned dbus_rdata.
    - A store loads mem_wb_reg_write=0 and mem_wb_valid=1.
- mem_stall = (IDLE && memop) || (ACCESS && !dbus_ready).
  - On the completing cycle mem_stall=0, so the next instruction is in EX/MEM at the following edge.
- Latency: a memop with zero wait states takes 2 cycles to MEM/WB. Each wait state adds 1 cycle.
- Back-to-back memops: a second memop seen in IDLE right after completion starts a new access. There is no overlap.
- Sizes by funct3:
  - 000 = byte, 001 = half, 010 = word.
  - 100 = LBU and 101 = LHU, zero-extended.
  - Any other value is treated as word.
- Byte enables:
  - Byte: be = 1<<addr[1:0].
  - Half: be = 0011 << {addr[1],0}.
  - Word: be = 1111.
- Store data is replicated across lanes (byte x4, half x2). dbus_addr = {addr[31:2], 00}.
- Load data is selected by addr[1:0] from dbus_rdata, then sign- or zero-extended.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): default behaviour is given under Optional Feature.
- Reset mid-ACCESS: the FSM returns to IDLE and dbus_req drops immediately. The interrupted instruction is lost, and the bus must tolerate the withdrawn request.
- mem_wb_alu_result always carries the latched or passed ALU result.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output ports misalign_trap (1) and misalign_addr (32).
  - A misaligned memop in IDLE issues no bus request and causes no stall.
  - misalign_trap pulses for 1 cycle on the next edge; misalign_addr holds the faulting address until the next trap.
  - MEM/WB gets a bubble (valid=0, reg_write=0).
  - Reset values: misalign_trap=0, misalign_addr=0.
- Undefined:
  - No extra ports.
  - Low address bits are ignored for the access size: half uses addr[0]=0, word uses addr[1:0]=00, then the access proceeds normally.

Decomposition:
- Package mem_pkg holds:
  - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants.
  - FSM state encodings ST_IDLE, ST_ACCESS.
  - Byte-enable base constants.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output the extended 32-bit value.
- The store lane/BE generator stays inline.

Test Plan:
- ADD with alu_result=0x1234, rd=5, no memop -> next edge: mem_wb_valid=1, reg_write=1, alu_result=0x1234, rd=5, mem_stall=0 throughout.
- LW at 0x100, dbus_ready=1 on the first ACCESS cycle, rdata=0xDEADBEEF:
  - mem_stall=1 for 1 cycle; dbus_addr=0x100, be=1111.
  - Cycle +2: read_data=0xDEADBEEF, mem_to_reg=1.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF0011, ready after 2 wait states:
  - be=1000; stall lasts 3 cycles.
  - LB gives read_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x202, store_data=0x0000ABCD -> dbus_we=1, addr=0x200, be=1100, wdata=0xABCDABCD; mem_wb_reg_write=0.
- LW with rd=0, then reset asserted mid-ACCESS:
  - First the LW completes with mem_wb_reg_write=0.
  - Then on the reset assertion: dbus_req=0 and all mem_wb_* = 0 immediately.
  - After release: IDLE, no spurious request.
- With MEM_MISALIGN_TRAP_EN, LW at 0x101 -> no dbus_req, misalign_trap=1 for one cycle, misalign_addr=0x101, mem_wb_valid=0. Without the macro -> access at 0x100 with be=1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: funct3 access codes, FSM encodings,
// access-size decode and byte-enable base patterns.
package mem_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      FUNCT3_LB, FUNCT3_LBU: f3_size = SZ_BYTE;
      FUNCT3_LH, FUNCT3_LHU: f3_size = SZ_HALF;
      default:               f3_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Ready/valid data-bus bundle between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dbus_req;
  logic              dbus_we;
  logic [ADDR_W-1:0] dbus_addr;
  logic [31:0]       dbus_wdata;
  logic [3:0]        dbus_be;
  logic              dbus_ready;
  logic [31:0]       dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_ready, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_ready, dbus_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a bus read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase

    case (funct3)
      FUNCT3_LB:  result = {{24{byte_v[7]}}, byte_v};
      FUNCT3_LBU: result = {24'h0, byte_v};
      FUNCT3_LH:  result = {{16{half_v[15]}}, half_v};
      FUNCT3_LHU: result = {16'h0, half_v};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: drives the data bus for loads/stores and builds MEM/WB.
// Optional misaligned-access trap is enabled with the MEM_MISALIGN_TRAP_EN macro.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_store_data,
  input  logic [4:0]      ex_mem_rd,
  input  logic            ex_mem_reg_write,
  input  logic            ex_mem_mem_read,
  input  logic            ex_mem_mem_write,
  input  logic            ex_mem_mem_to_reg,
  input  logic [2:0]      ex_mem_funct3,
  output logic            mem_stall,
  mem_stage_if.master     dbus,
  output logic            mem_wb_valid,
  output logic            mem_wb_reg_write,
  output logic [XLEN-1:0] mem_wb_read_data,
  output logic [XLEN-1:0] mem_wb_alu_result,
  output logic [4:0]      mem_wb_rd,
  output logic            mem_wb_mem_to_reg
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  state_e state_q, state_d;

  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [XLEN-1:0]   alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d, m2r_q, m2r_d, load_q, load_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic              wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
  logic [XLEN-1:0]   wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
  logic [4:0]        wb_rd_q, wb_rd_d;

  logic              memop, trap_hit;
  size_e             size;
  logic [1:0]        eff_off;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new, aligned;

  assign memop = ex_mem_valid && (ex_mem_mem_read || ex_mem_mem_write);
  assign size  = f3_size(ex_mem_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;

  assign misaligned = ((size == SZ_HALF) && ex_mem_alu_result[0]) ||
                      ((size == SZ_WORD) && (ex_mem_alu_result[1:0] != 2'b00));
  assign trap_hit      = memop && misaligned;
  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`else
  assign trap_hit = 1'b0;
`endif

  // Low address bits that cannot belong to the access size are forced to zero.
  always_comb begin
    eff_off   = 2'b00;
    be_new    = BE_WORD;
    wdata_new = ex_mem_store_data[31:0];
    case (size)
      SZ_BYTE: begin
        eff_off   = ex_mem_alu_result[1:0];
        be_new    = BE_BYTE << eff_off;
        wdata_new = {4{ex_mem_store_data[7:0]}};
      end
      SZ_HALF: begin
        eff_off   = {ex_mem_alu_result[1], 1'b0};
        be_new    = BE_HALF << eff_off;
        wdata_new = {2{ex_mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata  (dbus.dbus_rdata),
    .addr   (off_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    m2r_d      = m2r_q;
    load_d     = load_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wb_valid_d = wb_valid_q;
    wb_rw_d    = wb_rw_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_rd_d    = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif
    mem_stall  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_stall  = memop && !trap_hit;
        wb_alu_d   = ex_mem_alu_result;
        wb_rd_d    = ex_mem_rd;
        wb_m2r_d   = ex_mem_mem_to_reg;
        wb_rdata_d = '0;
        if (trap_hit) begin
          wb_valid_d  = 1'b0;
          wb_rw_d     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          trap_d      = 1'b1;
          trap_addr_d = ex_mem_alu_result;
`endif
        end else if (memop) begin
          state_d    = ST_ACCESS;
          req_d      = 1'b1;
          we_d       = ex_mem_mem_write;
          addr_d     = {ex_mem_alu_result[ADDR_W-1:2], 2'b00};
          be_d       = be_new;
          wdata_d    = wdata_new;
          alu_d      = ex_mem_alu_result;
          rd_d       = ex_mem_rd;
          rw_d       = ex_mem_reg_write;
          m2r_d      = ex_mem_mem_to_reg;
          load_d     = ex_mem_mem_read;
          f3_d       = ex_mem_funct3;
          off_d      = eff_off;
          wb_valid_d = 1'b0;
          wb_rw_d    = 1'b0;
        end else begin
          wb_valid_d = ex_mem_valid;
          wb_rw_d    = ex_mem_reg_write && ex_mem_valid && (ex_mem_rd != 5'd0);
        end
      end
      ST_ACCESS: begin
        mem_stall = !dbus.dbus_ready;
        if (dbus.dbus_ready) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          be_d       = 4'b0000;
          wb_valid_d = 1'b1;
          wb_rw_d    = rw_q && load_q && (rd_q != 5'd0);
          wb_m2r_d   = m2r_q;
          wb_rdata_d = load_q ? aligned : '0;
          wb_alu_d   = alu_q;
          wb_rd_d    = rd_q;
        end else begin
          wb_valid_d = 1'b0;
          wb_rw_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      alu_q      <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      m2r_q      <= 1'b0;
      load_q     <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      m2r_q      <= m2r_d;
      load_q     <= load_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
`endif
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;
  assign dbus.dbus_be    = be_q;

  assign mem_wb_valid      = wb_valid_q;
  assign mem_wb_reg_write  = wb_rw_q;
  assign mem_wb_read_data  = wb_rdata_q;
  assign mem_wb_alu_result = wb_alu_q;
  assign mem_wb_rd         = wb_rd_q;
  assign mem_wb_mem_to_reg = wb_m2r_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores,
// wait states, back-to-back accesses, reset mid-access and misaligned handling.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic [2:0]  ex_mem_funct3;
  logic        mem_stall;
  logic        mem_wb_valid, mem_wb_reg_write, mem_wb_mem_to_reg;
  logic [31:0] mem_wb_read_data, mem_wb_alu_result;
  logic [4:0]  mem_wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  int errors = 0;
  int checks = 0;

  mem_stage_if #(.ADDR_W(32)) dbus ();

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_mem_to_reg (ex_mem_mem_to_reg),
    .ex_mem_funct3     (ex_mem_funct3),
    .mem_stall         (mem_stall),
    .dbus              (dbus.master),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_read_data  (mem_wb_read_data),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_mem_to_reg (mem_wb_mem_to_reg)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_trap     (misalign_trap),
    .misalign_addr     (misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic m2r, input logic [2:0] f3);
    ex_mem_valid      = v;
    ex_mem_alu_result = alu;
    ex_mem_store_data = sd;
    ex_mem_rd         = rd;
    ex_mem_reg_write  = rw;
    ex_mem_mem_read   = mr;
    ex_mem_mem_write  = mw;
    ex_mem_mem_to_reg = m2r;
    ex_mem_funct3     = f3;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // Runs one access with the memop already on EX/MEM; captures the bus view.
  task automatic do_access(input int waits, input logic [31:0] rword, output int stalls,
                           output logic [31:0] a, output logic [3:0] be, output logic we,
                           output logic [31:0] wd, output logic held);
    stalls = 0;
    #1;
    if (mem_stall) stalls++;
    tick();
    a    = dbus.dbus_addr;
    be   = dbus.dbus_be;
    we   = dbus.dbus_we;
    wd   = dbus.dbus_wdata;
    held = dbus.dbus_req;
    for (int w = 0; w < waits; w++) begin
      if (mem_stall) stalls++;
      tick();
      if (!dbus.dbus_req || dbus.dbus_addr != a || dbus.dbus_be != be) held = 1'b0;
    end
    dbus.dbus_ready = 1'b1;
    dbus.dbus_rdata = rword;
    #1;
    if (mem_stall) stalls++;
    tick();
    dbus.dbus_ready = 1'b0;
    clear_ex();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ex(1'b1, 32'h100, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    tick();
    checks++;
    if ({dbus.dbus_req, dbus.dbus_we, dbus.dbus_be} !== 6'b0 || dbus.dbus_addr !== 32'h0 || dbus.dbus_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus req=%b we=%b be=%b addr=%h wdata=%h exp all 0",
                         dbus.dbus_req, dbus.dbus_we, dbus.dbus_be, dbus.dbus_addr, dbus.dbus_wdata);
    end
    checks++;
    if ({mem_wb_valid, mem_wb_reg_write, mem_wb_mem_to_reg, mem_wb_rd} !== 8'h0 ||
        mem_wb_read_data !== 32'h0 || mem_wb_alu_result !== 32'h0) begin
      errors++; $display("FAIL reset_wb valid=%b rw=%b rd=%0d data=%h alu=%h exp all 0",
                         mem_wb_valid, mem_wb_reg_write, mem_wb_rd, mem_wb_read_data, mem_wb_alu_result);
    end
    clear_ex();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_op();
    set_ex(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
    tick();
    checks++;
    if (mem_wb_valid !== 1'b1 || mem_wb_reg_write !== 1'b1 || mem_wb_alu_result !== 32'h1234 ||
        mem_wb_rd !== 5'd5 || mem_wb_mem_to_reg !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL alu_wb valid=%b rw=%b alu=%h rd=%0d stall=%b exp 1 1 1234 5 0",
                         mem_wb_valid, mem_wb_reg_write, mem_wb_alu_result, mem_wb_rd, mem_stall);
    end
    clear_ex();
    tick();
    checks++;
    if (mem_wb_valid !== 1'b0 || mem_wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL alu_idle_bubble valid=%b rw=%b exp 0 0", mem_wb_valid, mem_wb_reg_write);
    end
  endtask

  task automatic test_lw();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we, held;
    set_ex(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    do_access(0, 32'hDEADBEEF, st, a, be, we, wd, held);
    checks++;
    if (st != 1 || a !== 32'h100 || be !== 4'b1111 || we !== 1'b0 || held !== 1'b1) begin
      errors++; $display("FAIL lw_bus stalls=%0d addr=%h be=%b we=%b req=%b exp 1 100 1111 0 1", st, a, be, we, held);
    end
    checks++;
    if (mem_wb_valid !== 1'b1 || mem_wb_reg_write !== 1'b1 || mem_wb_read_data !== 32'hDEADBEEF ||
        mem_wb_mem_to_reg !== 1'b1 || mem_wb_rd !== 5'd7 || mem_wb_alu_result !== 32'h100) begin
      errors++; $display("FAIL lw_wb valid=%b rw=%b data=%h m2r=%b rd=%0d alu=%h exp 1 1 deadbeef 1 7 100",
                         mem_wb_valid, mem_wb_reg_write, mem_wb_read_data, mem_wb_mem_to_reg, mem_wb_rd, mem_wb_alu_result);
    end
    checks++;
    if (dbus.dbus_req !== 1'b0 || dbus.dbus_be !== 4'b0000) begin
      errors++; $display("FAIL lw_bus_release req=%b be=%b exp 0 0000", dbus.dbus_req, dbus.dbus_be);
    end
  endtask

  task automatic test_byte_loads();
    logic [2:0]  f3s[2]  = '{FUNCT3_LB, FUNCT3_LBU};
    logic [31:0] exps[2] = '{32'hFFFFFF80, 32'h00000080};
    int st; logic [31:0] a, wd; logic [3:0] be; logic we, held;
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, f3s[i]);
      do_access(2, 32'h80FF0011, st, a, be, we, wd, held);
      checks++;
      if (st != 3 || be !== 4'b1000 || a !== 32'h100 || held !== 1'b1) begin
        errors++; $display("FAIL byte_bus[%0d] stalls=%0d be=%b addr=%h held=%b exp 3 1000 100 1", i, st, be, a, held);
      end
      checks++;
      if (mem_wb_read_data !== exps[i] || mem_wb_valid !== 1'b1) begin
        errors++; $display("FAIL byte_data[%0d] got=%h valid=%b exp=%h 1", i, mem_wb_read_data, mem_wb_valid, exps[i]);
      end
    end
  endtask

  task automatic test_store_half();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we, held;
    set_ex(1'b1, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FUNCT3_SH);
    do_access(1, 32'h0, st, a, be, we, wd, held);
    checks++;
    if (we !== 1'b1 || a !== 32'h200 || be !== 4'b1100 || wd !== 32'hABCDABCD || st != 2) begin
      errors++; $display("FAIL sh_bus we=%b addr=%h be=%b wdata=%h stalls=%0d exp 1 200 1100 abcdabcd 2", we, a, be, wd, st);
    end
    checks++;
    if (mem_wb_reg_write !== 1'b0 || mem_wb_valid !== 1'b1 || dbus.dbus_we !== 1'b0) begin
      errors++; $display("FAIL sh_wb rw=%b valid=%b we_after=%b exp 0 1 0", mem_wb_reg_write, mem_wb_valid, dbus.dbus_we);
    end
  endtask

  task automatic test_half_and_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    set_ex(1'b1, 32'h101, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL trap_stall got=%b exp=0", mem_stall); end
    tick();
    clear_ex();
    checks++;
    if (misalign_trap !== 1'b1 || misalign_addr !== 32'h101 || dbus.dbus_req !== 1'b0 || mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL trap_pulse trap=%b addr=%h req=%b valid=%b exp 1 101 0 0",
                         misalign_trap, misalign_addr, dbus.dbus_req, mem_wb_valid);
    end
    tick();
    checks++;
    if (misalign_trap !== 1'b0 || misalign_addr !== 32'h101 || dbus.dbus_req !== 1'b0) begin
      errors++; $display("FAIL trap_end trap=%b addr=%h req=%b exp 0 101 0", misalign_trap, misalign_addr, dbus.dbus_req);
    end
`else
    logic [2:0]  f3s[4]  = '{FUNCT3_LH, FUNCT3_LHU, FUNCT3_LW, FUNCT3_LH};
    logic [31:0] adrs[4] = '{32'h102, 32'h102, 32'h101, 32'h103};
    logic [3:0]  bes[4]  = '{4'b1100, 4'b1100, 4'b1111, 4'b1100};
    logic [31:0] exps[4] = '{32'hFFFF8001, 32'h00008001, 32'h80011234, 32'hFFFF8001};
    int st; logic [31:0] a, wd; logic [3:0] be; logic we, held;
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, adrs[i], 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, f3s[i]);
      do_access(0, 32'h80011234, st, a, be, we, wd, held);
      checks++;
      if (a !== 32'h100 || be !== bes[i] || mem_wb_read_data !== exps[i] || mem_wb_alu_result !== adrs[i]) begin
        errors++; $display("FAIL half_mis[%0d] addr=%h be=%b data=%h alu=%h exp 100 %b %h %h",
                           i, a, be, mem_wb_read_data, mem_wb_alu_result, bes[i], exps[i], adrs[i]);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    tick();
    dbus.dbus_ready = 1'b1;
    dbus.dbus_rdata = 32'h11111111;
    tick();
    dbus.dbus_ready = 1'b0;
    set_ex(1'b1, 32'h304, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || mem_wb_read_data !== 32'h11111111 || mem_wb_rd !== 5'd3 || mem_wb_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first stall=%b data=%h rd=%0d valid=%b exp 1 11111111 3 1",
                         mem_stall, mem_wb_read_data, mem_wb_rd, mem_wb_valid);
    end
    tick();
    checks++;
    if (dbus.dbus_req !== 1'b1 || dbus.dbus_addr !== 32'h304 || mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second_req req=%b addr=%h valid=%b exp 1 304 0", dbus.dbus_req, dbus.dbus_addr, mem_wb_valid);
    end
    dbus.dbus_ready = 1'b1;
    dbus.dbus_rdata = 32'h22222222;
    tick();
    dbus.dbus_ready = 1'b0;
    clear_ex();
    checks++;
    if (mem_wb_read_data !== 32'h22222222 || mem_wb_rd !== 5'd4 || mem_wb_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second_wb data=%h rd=%0d valid=%b exp 22222222 4 1", mem_wb_read_data, mem_wb_rd, mem_wb_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we, held;
    set_ex(1'b1, 32'h380, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    do_access(0, 32'hCAFEF00D, st, a, be, we, wd, held);
    checks++;
    if (mem_wb_reg_write !== 1'b0 || mem_wb_valid !== 1'b1 || mem_wb_read_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rd0_wb rw=%b valid=%b data=%h exp 0 1 cafef00d", mem_wb_reg_write, mem_wb_valid, mem_wb_read_data);
    end
    set_ex(1'b1, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, FUNCT3_LW);
    tick();
    checks++;
    if (dbus.dbus_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%b exp=1", dbus.dbus_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dbus.dbus_req !== 1'b0 || mem_stall !== 1'b0 || mem_wb_valid !== 1'b0 || mem_wb_reg_write !== 1'b0 ||
        mem_wb_read_data !== 32'h0 || mem_wb_alu_result !== 32'h0 || mem_wb_rd !== 5'd0 || mem_wb_mem_to_reg !== 1'b0) begin
      errors++; $display("FAIL rst_mid req=%b stall=%b valid=%b rw=%b data=%h alu=%h rd=%0d m2r=%b exp all 0",
                         dbus.dbus_req, mem_stall, mem_wb_valid, mem_wb_reg_write, mem_wb_read_data,
                         mem_wb_alu_result, mem_wb_rd, mem_wb_mem_to_reg);
    end
    clear_ex();
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (dbus.dbus_req !== 1'b0 || dbus.dbus_be !== 4'b0000 || mem_stall !== 1'b0 || mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after req=%b be=%b stall=%b valid=%b exp 0 0000 0 0",
                         dbus.dbus_req, dbus.dbus_be, mem_stall, mem_wb_valid);
    end
  endtask

  initial begin
    dbus.dbus_ready = 1'b0;
    dbus.dbus_rdata = 32'h0;
    clear_ex();
    test_reset();
    test_alu_op();
    test_lw();
    test_byte_loads();
    test_store_half();
    test_half_and_misalign();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
